// File: rtl/spi_slave_if.sv
// SPI slave front-end: command byte selects R/W and start index, then
// data bytes are written to or read from a register file with auto-increment.
module spi_slave_if (
    input  logic                  spi_clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  sdi,
    input  logic [7:0]            read_data,
    output logic                  sdo,
    output logic [7:0]            spi_if_dout,
    output logic [2:0]            spi_if_index,
    output logic                  spi_if_wr_en,
    output logic                  frame_abort
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state, state_d;
    logic [CW-1:0] bit_cnt, bit_cnt_d;
    logic [DW-2:0] shreg, shreg_d;
    logic [DW-1:0] dout_d;
    logic [AW-1:0] index_d;
    logic          wr_en_d;
    logic          abort_d;
    logic          rw, rw_d;
    logic [DW-1:0] rd_cap, rd_cap_d;
    logic          hold_off, hold_off_d;

    // State and datapath registers
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            spi_if_dout  <= '0;
            spi_if_index <= '0;
            spi_if_wr_en <= 1'b0;
            frame_abort  <= 1'b0;
            rw           <= 1'b0;
            rd_cap       <= '0;
            hold_off     <= 1'b1;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            shreg        <= shreg_d;
            spi_if_dout  <= dout_d;
            spi_if_index <= index_d;
            spi_if_wr_en <= wr_en_d;
            frame_abort  <= abort_d;
            rw           <= rw_d;
            rd_cap       <= rd_cap_d;
            hold_off     <= hold_off_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        dout_d     = spi_if_dout;
        index_d    = spi_if_wr_en ? spi_if_index + AW'(1) : spi_if_index;
        wr_en_d    = 1'b0;
        abort_d    = 1'b0;
        rw_d       = rw;
        rd_cap_d   = rd_cap;
        hold_off_d = hold_off;

        if (cs_n) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            abort_d    = (bit_cnt != '0);
            hold_off_d = 1'b0;
        end else if (!(state == IDLE && hold_off)) begin
            // A frame cut by reset only restarts after cs_n has been seen high
            bit_cnt_d = bit_cnt + CW'(1);
            shreg_d   = {shreg[DW-3:0], sdi};
            case (state)
                IDLE: state_d = CMD;
                CMD: begin
                    if (bit_cnt == CW'(7)) begin
                        state_d = DATA;
                        index_d = {shreg[1:0], sdi};
                        rw_d    = shreg[DW-2];
                    end
                end
                DATA: begin
                    if (rw) begin
                        if (bit_cnt == CW'(7)) begin
                            dout_d  = {shreg, sdi};
                            wr_en_d = 1'b1;
                        end
                    end else begin
                        if (bit_cnt == '0) rd_cap_d = read_data;
                        if (bit_cnt == CW'(7)) index_d = spi_if_index + AW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read serialiser: MSB straight from the register file, rest from the capture
    always_comb begin
        sdo = 1'b0;
        if (state == DATA && !rw) begin
            sdo = (bit_cnt == '0) ? read_data[DW-1] : rd_cap[CW'(7) - bit_cnt];
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if.
module tb_spi_slave_if;

    logic       spi_clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       sdi;
    logic [7:0] read_data;
    logic       sdo;
    logic [7:0] spi_if_dout;
    logic [2:0] spi_if_index;
    logic       spi_if_wr_en;
    logic       frame_abort;

    logic [7:0] rf [8];
    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int aborts = 0;
    logic [7:0] rx;
    int s0, a0;

    spi_slave_if dut (
        .spi_clk(spi_clk), .rst(rst), .cs_n(cs_n), .sdi(sdi),
        .read_data(read_data), .sdo(sdo), .spi_if_dout(spi_if_dout),
        .spi_if_index(spi_if_index), .spi_if_wr_en(spi_if_wr_en),
        .frame_abort(frame_abort)
    );

    always #5 spi_clk = ~spi_clk;

    assign read_data = rf[spi_if_index];

    always @(negedge spi_clk) begin
        if (spi_if_wr_en === 1'b1) strobes++;
        if (frame_abort === 1'b1) aborts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit with cs_n low; sample sdo before the sampling edge
    task automatic send_bit(input logic b, output logic so);
        @(negedge spi_clk);
        cs_n = 1'b0;
        sdi  = b;
        #1 so = sdo;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
        logic so;
        for (int i = 7; i >= 0; i--) begin
            send_bit(tx[i], so);
            rxb[i] = so;
        end
    endtask

    task automatic deselect();
        @(negedge spi_clk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        @(posedge spi_clk);
        #1;
    endtask

    initial begin
        logic so;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        rf[1] = 8'h2A;
        rf[2] = 8'h05;
        rst = 1'b1; cs_n = 1'b1; sdi = 1'b0;
        repeat (2) @(posedge spi_clk);
        #1;
        chk("rst_dout", 32'(spi_if_dout), 32'h00);
        chk("rst_index", 32'(spi_if_index), 32'd0);
        chk("rst_wr_en", 32'(spi_if_wr_en), 32'd0);
        chk("rst_abort", 32'(frame_abort), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);
        @(negedge spi_clk);
        rst = 1'b0;
        deselect();

        // Single write
        s0 = strobes;
        xfer(8'h80, rx);
        chk("w1_cmd_sdo", 32'(rx), 32'h00);
        xfer(8'hF8, rx);
        chk("w1_data_sdo", 32'(rx), 32'h00);
        chk("w1_wr_en", 32'(spi_if_wr_en), 32'd1);
        chk("w1_index", 32'(spi_if_index), 32'd0);
        chk("w1_dout", 32'(spi_if_dout), 32'hF8);
        deselect();
        chk("w1_wr_clr", 32'(spi_if_wr_en), 32'd0);
        chk("w1_index_inc", 32'(spi_if_index), 32'd1);
        chk("w1_no_abort", 32'(frame_abort), 32'd0);
        chk("w1_strobes", 32'(strobes - s0), 32'd1);

        // Burst write wrapping index 7 -> 0
        s0 = strobes;
        xfer(8'h87, rx);
        xfer(8'h11, rx);
        chk("w2_b0_wr_en", 32'(spi_if_wr_en), 32'd1);
        chk("w2_b0_index", 32'(spi_if_index), 32'd7);
        chk("w2_b0_dout", 32'(spi_if_dout), 32'h11);
        xfer(8'h22, rx);
        chk("w2_b1_wr_en", 32'(spi_if_wr_en), 32'd1);
        chk("w2_b1_index", 32'(spi_if_index), 32'd0);
        chk("w2_b1_dout", 32'(spi_if_dout), 32'h22);
        deselect();
        chk("w2_index_end", 32'(spi_if_index), 32'd1);
        chk("w2_strobes", 32'(strobes - s0), 32'd2);

        // Burst read from index 1
        s0 = strobes;
        xfer(8'h01, rx);
        chk("r_cmd_sdo", 32'(rx), 32'h00);
        xfer(8'h00, rx);
        chk("r_byte0", 32'(rx), 32'h2A);
        xfer(8'h00, rx);
        chk("r_byte1", 32'(rx), 32'h05);
        deselect();
        chk("r_index_end", 32'(spi_if_index), 32'd3);
        chk("r_dout_hold", 32'(spi_if_dout), 32'h22);
        chk("r_strobes", 32'(strobes - s0), 32'd0);

        // Abort after 5 data bits of a write
        s0 = strobes; a0 = aborts;
        xfer(8'h84, rx);
        for (int i = 0; i < 5; i++) send_bit(1'b1, so);
        deselect();
        chk("ab_pulse", 32'(frame_abort), 32'd1);
        chk("ab_index", 32'(spi_if_index), 32'd4);
        chk("ab_dout", 32'(spi_if_dout), 32'h22);
        @(posedge spi_clk);
        #1;
        chk("ab_pulse_clr", 32'(frame_abort), 32'd0);
        chk("ab_count", 32'(aborts - a0), 32'd1);
        chk("ab_strobes", 32'(strobes - s0), 32'd0);

        // Reset mid write byte, cs_n held low through and after reset
        s0 = strobes; a0 = aborts;
        xfer(8'h82, rx);
        for (int i = 0; i < 3; i++) send_bit(1'b1, so);
        @(negedge spi_clk);
        rst = 1'b1;
        @(posedge spi_clk);
        #1;
        chk("mr_dout", 32'(spi_if_dout), 32'h00);
        chk("mr_index", 32'(spi_if_index), 32'd0);
        chk("mr_wr_en", 32'(spi_if_wr_en), 32'd0);
        chk("mr_abort", 32'(frame_abort), 32'd0);
        chk("mr_sdo", 32'(sdo), 32'd0);
        @(negedge spi_clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, so);
        deselect();
        chk("mr_no_abort", 32'(aborts - a0), 32'd0);
        chk("mr_no_strobe", 32'(strobes - s0), 32'd0);
        chk("mr_index_hold", 32'(spi_if_index), 32'd0);
        xfer(8'h85, rx);
        xfer(8'h3C, rx);
        chk("mr_w_wr_en", 32'(spi_if_wr_en), 32'd1);
        chk("mr_w_index", 32'(spi_if_index), 32'd5);
        chk("mr_w_dout", 32'(spi_if_dout), 32'h3C);
        deselect();
        chk("mr_w_index_inc", 32'(spi_if_index), 32'd6);

        // Command-only frame
        s0 = strobes; a0 = aborts;
        xfer(8'h03, rx);
        chk("co_sdo", 32'(rx), 32'h00);
        deselect();
        chk("co_index", 32'(spi_if_index), 32'd3);
        chk("co_dout", 32'(spi_if_dout), 32'h3C);
        chk("co_strobes", 32'(strobes - s0), 32'd0);
        chk("co_no_abort", 32'(aborts - a0), 32'd0);
        chk("co_sdo_idle", 32'(sdo), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
